// File: rtl/mbldcm_hall_decoder.sv
// mbldcm_hall_decoder: filtered Hall decoder producing phase, direction, edge period and stall/error flags
module mbldcm_hall_decoder #(
  parameter logic [31:0] pFilterCycles = 32'd8,
  parameter logic [31:0] pStallCycles  = 32'd50_000_000
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [2:0]  iHall,
  input  logic        iEnable,
  input  logic        iClearError,
  output logic [2:0]  oPhaseUpdate,
  output logic        oLatchPhaseUpdate,
  output logic        oPhaseValid,
  output logic        oDirection,
  output logic [31:0] oPeriod,
  output logic        oPeriodValid,
  output logic        oStall,
  output logic        oHallError
);
  logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d, stable_q, stable_d, phase_q, phase_d;
  logic [31:0] filt_q, filt_d, cnt_q, cnt_d, period_q, period_d;
  logic        latch_q, latch_d, valid_q, valid_d, dir_q, dir_d, pv_q, pv_d;
  logic        stall_q, stall_d, err_q, err_d, last_adj_q, last_adj_d;
  logic        accept, code_ok, fwd, rev, adj, acc_v, acc_adj, stall_hit;
  logic [2:0]  p, q_next, q_prev;

  // filter the synchronised code, decode it and work out every output update for this edge
  always_comb begin
    code_ok   = cand_q != 3'b000 && cand_q != 3'b111;
    p         = cand_q == 3'b001 ? 3'd0 : cand_q == 3'b011 ? 3'd1 : cand_q == 3'b010 ? 3'd2 :
                cand_q == 3'b110 ? 3'd3 : cand_q == 3'b100 ? 3'd4 : 3'd5;
    q_next    = phase_q == 3'd5 ? 3'd0 : phase_q + 3'd1;
    q_prev    = phase_q == 3'd0 ? 3'd5 : phase_q - 3'd1;
    accept    = cand_q == sync2_q && cand_q != stable_q && filt_q == pFilterCycles - 32'd1;
    fwd       = valid_q && p == q_next;
    rev       = valid_q && p == q_prev;
    adj       = fwd || rev;
    acc_v     = accept && code_ok;
    acc_adj   = acc_v && adj;
    stall_hit = cnt_q >= pStallCycles;
    sync1_d    = iHall;
    sync2_d    = sync1_q;
    cand_d     = sync2_q;
    filt_d     = (cand_q != sync2_q || cand_q == stable_q || accept) ? 32'd0 : filt_q + 32'd1;
    stable_d   = accept ? cand_q : stable_q;
    cnt_d      = acc_v ? 32'd1 : (&cnt_q) ? cnt_q : cnt_q + 32'd1;
    phase_d    = acc_v ? p : phase_q;
    latch_d    = acc_v && iEnable;
    valid_d    = accept ? code_ok : valid_q;
    dir_d      = (acc_v && fwd) ? 1'b1 : (acc_v && rev) ? 1'b0 : dir_q;
    period_d   = acc_adj ? cnt_q : period_q;
    pv_d       = acc_adj ? (last_adj_q && !stall_q) : (stall_hit && !acc_v) ? 1'b0 : pv_q;
    stall_d    = acc_v ? 1'b0 : stall_hit ? 1'b1 : stall_q;
    last_adj_d = acc_v ? adj : last_adj_q;
    err_d      = ((accept && !code_ok) || (acc_v && valid_q && !adj)) ? 1'b1 : iClearError ? 1'b0 : err_q;
  end

  // state registers, cleared immediately by reset
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      filt_q     <= '0;
      cnt_q      <= '0;
      phase_q    <= '0;
      latch_q    <= 1'b0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b0;
      period_q   <= '0;
      pv_q       <= 1'b0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
      last_adj_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      latch_q    <= latch_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      period_q   <= period_d;
      pv_q       <= pv_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
      last_adj_q <= last_adj_d;
    end
  end

  assign oPhaseUpdate      = phase_q;
  assign oLatchPhaseUpdate = latch_q;
  assign oPhaseValid       = valid_q;
  assign oDirection        = dir_q;
  assign oPeriod           = period_q;
  assign oPeriodValid      = pv_q;
  assign oStall            = stall_q;
  assign oHallError        = err_q;
endmodule
